ecc_rd_resp_stage: RTL and testbench

//  Registered read-response stage directly downstream of the SEC-DED checker.

---
 rtl/ecc_rd_resp_stage_if.sv | 35 +++
 rtl/ecc_rd_resp_stage.sv | 163 ++++++++++++++++
 tb/tb_ecc_rd_resp_stage.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_rd_resp_stage_if.sv
// Read-response beat bus for the ECC response stage: upstream beat side and
// downstream beat side, each with a valid/ready handshake.
interface ecc_rd_resp_stage_if #(
    parameter int unsigned AW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_data;
    logic          in_single_err;
    logic          in_double_err;

    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_data;
    logic          out_ue;
    logic          out_ce;

    // stage side
    modport slave (
        input  in_valid, in_addr, in_data, in_single_err, in_double_err,
        output in_ready,
        output out_valid, out_addr, out_data, out_ue, out_ce,
        input  out_ready
    );

    // driver / consumer side
    modport master (
        output in_valid, in_addr, in_data, in_single_err, in_double_err,
        input  in_ready,
        input  out_valid, out_addr, out_data, out_ue, out_ce,
        output out_ready
    );
endinterface

// File: rtl/ecc_rd_resp_stage.sv
// Registered read-response stage after the SEC-DED checker: classifies beats,
// forwards them through a 2-entry skid buffer, counts CE/UE, logs first error.
module ecc_rd_resp_stage #(
    parameter int unsigned AW        = 8,
    parameter int unsigned CNT_W     = 16,
    parameter bit          POISON_UE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    ecc_rd_resp_stage_if.slave bus,
    input  logic               cnt_clear,
    output logic [CNT_W-1:0]   ce_count,
    output logic [CNT_W-1:0]   ue_count,
    output logic               log_valid,
    output logic [AW-1:0]      log_addr,
    output logic               log_is_ue,
    input  logic               log_clear,
    output logic               irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Buffer storage: main drives the outputs, skid catches one beat on stall
    logic          main_valid, skid_valid;
    logic [AW-1:0] main_addr,  skid_addr;
    logic [31:0]   main_data,  skid_data;
    logic          main_ue,    skid_ue;
    logic          main_ce,    skid_ce;
    logic          ready_q;

    logic          in_ue, in_ce;
    logic [31:0]   in_dat;
    logic          accept, pop;
    logic          main_valid_d, skid_valid_d;
    logic          load_main_in, load_main_skid, load_skid;

    logic [CNT_W-1:0] ce_count_d, ue_count_d;
    logic             log_valid_d, log_is_ue_d, irq_d;
    logic [AW-1:0]    log_addr_d;
    logic             base_valid, base_is_ue, capture;

    // Beat classification and optional poisoning of uncorrectable data
    always_comb begin
        in_ue  = bus.in_double_err;
        in_ce  = bus.in_single_err & ~bus.in_double_err;
        in_dat = (POISON_UE && in_ue) ? 32'hFFFF_FFFF : bus.in_data;
        accept = bus.in_valid & ready_q;
        pop    = main_valid & bus.out_ready;
    end

    // Buffer steering; a full skid always drains into main before new beats enter
    always_comb begin
        main_valid_d   = main_valid;
        skid_valid_d   = skid_valid;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (skid_valid) begin
            if (pop) begin
                load_main_skid = 1'b1;
                skid_valid_d   = 1'b0;
            end
        end else if (main_valid && !bus.out_ready) begin
            if (accept) begin
                load_skid    = 1'b1;
                skid_valid_d = 1'b1;
            end
        end else begin
            main_valid_d = accept;
            load_main_in = accept;
        end
    end

    // Saturating counters; a clear still lets a same-cycle beat count as one
    always_comb begin
        ce_count_d = cnt_clear ? '0 : ce_count;
        ue_count_d = cnt_clear ? '0 : ue_count;
        if (accept && in_ce && ce_count_d != CNT_MAX)
            ce_count_d = ce_count_d + CNT_W'(1);
        if (accept && in_ue && ue_count_d != CNT_MAX)
            ue_count_d = ue_count_d + CNT_W'(1);
    end

    // First-error log with UE priority; clear is applied before capture
    always_comb begin
        base_valid  = log_clear ? 1'b0 : log_valid;
        base_is_ue  = log_clear ? 1'b0 : log_is_ue;
        capture     = accept & (in_ue | in_ce) & (~base_valid | (in_ue & ~base_is_ue));
        log_valid_d = base_valid;
        log_is_ue_d = base_is_ue;
        log_addr_d  = log_clear ? '0 : log_addr;
        irq_d       = log_clear ? 1'b0 : irq;
        if (capture) begin
            log_valid_d = 1'b1;
            log_is_ue_d = in_ue;
            log_addr_d  = bus.in_addr;
            irq_d       = irq_d | in_ue;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_addr  <= '0;
            main_data  <= '0;
            main_ue    <= 1'b0;
            main_ce    <= 1'b0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
            skid_ue    <= 1'b0;
            skid_ce    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            ready_q    <= ~skid_valid_d;
            if (load_main_in) begin
                main_addr <= bus.in_addr;
                main_data <= in_dat;
                main_ue   <= in_ue;
                main_ce   <= in_ce;
            end else if (load_main_skid) begin
                main_addr <= skid_addr;
                main_data <= skid_data;
                main_ue   <= skid_ue;
                main_ce   <= skid_ce;
            end
            if (load_skid) begin
                skid_addr <= bus.in_addr;
                skid_data <= in_dat;
                skid_ue   <= in_ue;
                skid_ce   <= in_ce;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_count  <= '0;
            ue_count  <= '0;
            log_valid <= 1'b0;
            log_addr  <= '0;
            log_is_ue <= 1'b0;
            irq       <= 1'b0;
        end else begin
            ce_count  <= ce_count_d;
            ue_count  <= ue_count_d;
            log_valid <= log_valid_d;
            log_addr  <= log_addr_d;
            log_is_ue <= log_is_ue_d;
            irq       <= irq_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = main_valid;
    assign bus.out_addr  = main_addr;
    assign bus.out_data  = main_data;
    assign bus.out_ue    = main_ue;
    assign bus.out_ce    = main_ce;

endmodule

// File: tb/tb_ecc_rd_resp_stage.sv
// Directed bench for ecc_rd_resp_stage: queue-based reference model checked
// every cycle, plus hand-computed literal checks at key points.
module tb_ecc_rd_resp_stage;

    localparam int unsigned AW    = 8;
    localparam int unsigned CNT_W = 2;
    localparam int          CMAX  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cnt_clear = 1'b0;
    logic log_clear = 1'b0;
    logic [CNT_W-1:0] ce_count, ue_count;
    logic log_valid, log_is_ue, irq;
    logic [AW-1:0] log_addr;

    ecc_rd_resp_stage_if #(.AW(AW)) bus ();

    ecc_rd_resp_stage #(.AW(AW), .CNT_W(CNT_W), .POISON_UE(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cnt_clear(cnt_clear), .ce_count(ce_count), .ue_count(ue_count),
        .log_valid(log_valid), .log_addr(log_addr), .log_is_ue(log_is_ue),
        .log_clear(log_clear), .irq(irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: FIFO of at most two accepted beats, plain-integer counters
    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
        bit            ue;
        bit            ce;
    } beat_t;

    beat_t         q[$];
    int            m_ce = 0, m_ue = 0;
    bit            m_lv = 0, m_lue = 0, m_irq = 0;
    logic [AW-1:0] m_la = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ce = 0; m_ue = 0; m_lv = 0; m_lue = 0; m_irq = 0; m_la = '0;
        end else begin
            bit acc, pop, ue, ce;
            beat_t b;
            acc = bus.in_valid && (q.size() < 2);
            pop = (q.size() > 0) && bus.out_ready;
            ue  = bus.in_double_err;
            ce  = bus.in_single_err && !bus.in_double_err;
            if (pop) void'(q.pop_front());
            if (acc) begin
                b.a  = bus.in_addr;
                b.d  = ue ? 32'hFFFF_FFFF : bus.in_data;
                b.ue = ue;
                b.ce = ce;
                q.push_back(b);
            end
            if (cnt_clear) begin m_ce = 0; m_ue = 0; end
            if (acc && ce && m_ce < CMAX) m_ce++;
            if (acc && ue && m_ue < CMAX) m_ue++;
            if (log_clear) begin m_lv = 0; m_lue = 0; m_irq = 0; end
            if (acc && (ue || ce) && (!m_lv || (ue && !m_lue))) begin
                m_lv = 1; m_la = bus.in_addr; m_lue = ue;
                if (ue) m_irq = 1;
            end
        end
    end

    // Compare process, opposite edge from the model update
    always @(negedge clk) begin
        chk("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_addr", 32'(bus.out_addr), 32'(q[0].a));
            chk("out_data", bus.out_data, q[0].d);
            chk("out_ue",   32'(bus.out_ue), 32'(q[0].ue));
            chk("out_ce",   32'(bus.out_ce), 32'(q[0].ce));
        end
        chk("ce_count",  32'(ce_count),  32'(m_ce));
        chk("ue_count",  32'(ue_count),  32'(m_ue));
        chk("log_valid", 32'(log_valid), 32'(m_lv));
        if (m_lv) begin
            chk("log_addr",  32'(log_addr),  32'(m_la));
            chk("log_is_ue", 32'(log_is_ue), 32'(m_lue));
        end
        chk("irq", 32'(irq), 32'(m_irq));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic se, input logic de);
        bus.in_valid      = v;
        bus.in_addr       = a;
        bus.in_data       = d;
        bus.in_single_err = se;
        bus.in_double_err = de;
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  bus.out_data,       32'd0);
        chk("rst_ce_count",  32'(ce_count),      32'd0);
        chk("rst_log_valid", 32'(log_valid),     32'd0);
        rst = 1'b0;

        // 1: clean stream, one-cycle latency, in order
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, AW'(i), 32'hA500_0000 + 32'(i), 1'b0, 1'b0);
            step();
            chk("t1_out_addr",  32'(bus.out_addr),  32'(i));
            chk("t1_in_ready",  32'(bus.in_ready),  32'd1);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        chk("t1_drained",   32'(bus.out_valid), 32'd0);
        chk("t1_ce_count",  32'(ce_count),      32'd0);
        chk("t1_log_valid", 32'(log_valid),     32'd0);

        // 2: CE then UE; UE takes over the log and is poisoned
        drive(1'b1, 8'h10, 32'h0000_1111, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'h20, 32'h0000_2222, 1'b0, 1'b1);
        step();
        chk("t2_out_addr", 32'(bus.out_addr), 32'h20);
        chk("t2_out_data", bus.out_data,      32'hFFFF_FFFF);
        chk("t2_out_ue",   32'(bus.out_ue),   32'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        chk("t2_ce_count",  32'(ce_count),  32'd1);
        chk("t2_ue_count",  32'(ue_count),  32'd1);
        chk("t2_log_addr",  32'(log_addr),  32'h20);
        chk("t2_log_is_ue", 32'(log_is_ue), 32'd1);
        chk("t2_irq",       32'(irq),       32'd1);

        // 3: stall four cycles with beats offered; only two accepted
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h50 + AW'(i), 32'h5000_0000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t3_out_addr", 32'(bus.out_addr), 32'h50);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("t3_second",   32'(bus.out_addr),  32'h51);
        chk("t3_ready_up", 32'(bus.in_ready),  32'd1);
        step();
        chk("t3_empty",    32'(bus.out_valid), 32'd0);

        // 4: CE counter saturation, then clear with same-cycle CE
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h80 + AW'(i), 32'(i), 1'b1, 1'b0);
            step();
        end
        chk("t4_sat", 32'(ce_count), 32'd3);
        chk("t4_log_kept", 32'(log_addr), 32'h20);
        drive(1'b1, 8'h88, 32'h8, 1'b1, 1'b0);
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("t4_clr_ce", 32'(ce_count), 32'd1);
        chk("t4_clr_ue", 32'(ue_count), 32'd0);

        // 5: log clear interactions and UE priority over CE
        log_clear = 1'b1;
        step();
        log_clear = 1'b0;
        chk("t5_empty", 32'(log_valid), 32'd0);
        chk("t5_noirq", 32'(irq),       32'd0);
        drive(1'b1, 8'h30, 32'h3, 1'b0, 1'b1);
        step();
        chk("t5_addr30", 32'(log_addr), 32'h30);
        chk("t5_irq30",  32'(irq),      32'd1);
        drive(1'b1, 8'h40, 32'h4, 1'b0, 1'b1);
        log_clear = 1'b1;
        step();
        chk("t5_addr40", 32'(log_addr), 32'h40);
        chk("t5_irq40",  32'(irq),      32'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        log_clear = 1'b0;
        chk("t5_cleared", 32'(log_valid), 32'd0);
        chk("t5_irq_off", 32'(irq),       32'd0);
        drive(1'b1, 8'h60, 32'h6, 1'b1, 1'b0);
        step();
        chk("t5_ce_log", 32'(log_is_ue), 32'd0);
        chk("t5_ce_irq", 32'(irq),       32'd0);
        drive(1'b1, 8'h70, 32'h7, 1'b0, 1'b1);
        step();
        drive(1'b1, 8'h71, 32'h7, 1'b1, 1'b0);
        step();
        chk("t5_ue_kept", 32'(log_addr), 32'h70);
        chk("t5_ue_irq",  32'(irq),      32'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();

        // 6: asynchronous reset while both entries are full and stalled
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h90, 32'h9, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'h91, 32'h9, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'h92, 32'h9, 1'b1, 1'b0);
        step();
        chk("t6_full", 32'(bus.in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_in_ready",  32'(bus.in_ready),  32'd1);
        chk("t6_ce_count",  32'(ce_count),      32'd0);
        chk("t6_ue_count",  32'(ue_count),      32'd0);
        chk("t6_log_valid", 32'(log_valid),     32'd0);
        chk("t6_irq",       32'(irq),           32'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("t6_post_empty", 32'(bus.out_valid), 32'd0);

        // Mixed traffic with irregular back-pressure, checked by the model
        for (int i = 0; i < 60; i++) begin
            drive(1'(i % 3 != 2), AW'(8'hC0 + i), 32'h1234_0000 ^ 32'(i * 37),
                  1'(i % 5 == 1), 1'(i % 11 == 7));
            bus.out_ready = 1'(i % 4 != 0 && i % 7 != 3);
            cnt_clear     = 1'(i == 40);
            log_clear     = 1'(i == 25);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        cnt_clear = 1'b0;
        log_clear = 1'b0;
        step();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
